// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// rippling the carry between chunks through a single register.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_idx;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_chunk_ext;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_ovf;

  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_idx == LAST);

  // Operands shift right each cycle, so the active chunk is always the low CHUNK bits.
  assign w_sum       = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_chunk_ext = WIDTH'(w_sum[CHUNK-1:0]);
  assign w_acc_next  = (r_acc >> CHUNK) | (w_chunk_ext << (WIDTH - CHUNK));
  // a^b^s at the MSB recovers the carry into the MSB.
  assign w_ovf       = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == S_RUN);
    o_done = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      o_sum       <= '0;
      o_carry_out <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction folds into addition: invert B and the borrow-in.
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_carry_in ^ i_sub;
      r_acc   <= '0;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_acc   <= w_acc_next;
      r_carry <= w_sum[CHUNK];
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        o_sum       <= w_acc_next;
        o_carry_out <= w_sum[CHUNK];
        o_overflow  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: 8-bit/4-bit-chunk instance plus a 32-bit single-chunk instance.
module tb_multicycle_adder;

  typedef struct {
    logic [7:0] sum;
    logic       co;
    logic       ov;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    exp_t       e;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } vec32_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, cin, sub, busy, done, co, ov;
  logic [7:0] a, b, sum;

  logic        s_start, s_cin, s_sub, s_busy, s_done, s_co, s_ov;
  logic [31:0] s_a, s_b, s_sum;

  multicycle_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .i_carry_in(cin), .i_sub(sub), .o_busy(busy), .o_done(done),
    .o_sum(sum), .o_carry_out(co), .o_overflow(ov)
  );

  multicycle_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_a(s_a), .i_b(s_b),
    .i_carry_in(s_cin), .i_sub(s_sub), .o_busy(s_busy), .o_done(s_done),
    .o_sum(s_sum), .o_carry_out(s_co), .o_overflow(s_ov)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference by arithmetic definition: signed range for overflow, unsigned compare for carry/borrow.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic mcin, input logic msub);
    exp_t r;
    int   sa, sbv, sres, ua, ub;
    sa  = int'($signed(ma));
    sbv = int'($signed(mb));
    ua  = int'(ma);
    ub  = int'(mb);
    sres = msub ? (sa - sbv - int'(mcin)) : (sa + sbv + int'(mcin));
    r.sum = msub ? 8'(ua - ub - int'(mcin)) : 8'(ua + ub + int'(mcin));
    r.co  = msub ? (ua >= ub + int'(mcin)) : (ua + ub + int'(mcin) > 255);
    r.ov  = (sres > 127) || (sres < -128);
    return r;
  endfunction

  task automatic drive8(input logic [7:0] da, input logic [7:0] db, input logic dcin,
                        input logic dsub, input exp_t e);
    a = da; b = db; cin = dcin; sub = dsub; start = 1'b1;
    sb.push_back(e);
  endtask

  // Counts falling edges from the drive until o_done; operands are scrambled while running.
  task automatic wait_done8(input int exp_n, input bit keep_start,
                            input bit check_hold, input logic [7:0] held);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!keep_start) start = 1'b0;
      if (n == 1) begin
        chk("busy_in_run", 32'(busy), 32'd1);
        chk("done_low_in_run", 32'(done), 32'd0);
        if (check_hold) chk("sum_held", 32'(sum), 32'(held));
      end
      if (!done) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
    end while (!done && n < 20);
    chk("latency", 32'(n), 32'(exp_n));
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sum", 32'(sum), 32'(e.sum));
      chk("carry", 32'(co), 32'(e.co));
      chk("overflow", 32'(ov), 32'(e.ov));
    end
  endtask

  vec_t       vt[12];
  vec32_t     v32[3];
  logic [7:0] prev;
  exp_t       e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'hBD, 8'hA5, 1'b0, 1'b0, '{8'h62, 1'b1, 1'b1}};
    vt[1] = '{8'hF0, 8'h0F, 1'b0, 1'b0, '{8'hFF, 1'b0, 1'b0}};
    vt[2] = '{8'hF0, 8'h8F, 1'b0, 1'b0, '{8'h7F, 1'b1, 1'b1}};
    vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, '{8'hFE, 1'b0, 1'b0}};
    vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1}};
    vt[5] = '{8'h7F, 8'h00, 1'b1, 1'b0, '{8'h80, 1'b0, 1'b1}};
    vt[6] = '{8'h10, 8'h01, 1'b1, 1'b1, '{8'h0E, 1'b1, 1'b0}};
    for (int i = 7; i < 12; i++) begin
      vt[i].a = 8'($urandom); vt[i].b = 8'($urandom);
      vt[i].cin = 1'($urandom); vt[i].sub = 1'($urandom);
      vt[i].e = model(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
    end
    v32[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    v32[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    v32[2] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ov), 32'd0);
    chk("rst32_sum", s_sum, 32'd0);
    chk("rst32_done", 32'(s_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: alternate back-to-back starts from DONE and starts from IDLE.
    prev = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 1) begin
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
      end
      drive8(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].e);
      wait_done8(3, 1'b0, 1'b1, prev);
      prev = vt[i].e.sum;
    end
    @(negedge clk);

    // Start held high: one result every 3 cycles, RUN-time starts ignored.
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ha, hb;
      logic       hc, hs;
      ha = 8'($urandom); hb = 8'($urandom); hc = 1'($urandom); hs = 1'($urandom);
      e = model(ha, hb, hc, hs);
      drive8(ha, hb, hc, hs, e);
      wait_done8(3, 1'b1, (k > 0), prev);
      prev = e.sum;
    end
    start = 1'b0;
    @(negedge clk);
    chk("held_end_busy", 32'(busy), 32'd0);
    chk("held_end_done", 32'(done), 32'd0);

    // Known nonzero result, then reset one cycle after the next start.
    drive8(8'hBD, 8'hA5, 1'b0, 1'b0, '{8'h62, 1'b1, 1'b1});
    wait_done8(3, 1'b0, 1'b0, 8'h00);
    drive8(8'h55, 8'h22, 1'b0, 1'b0, '{8'h77, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_carry", 32'(co), 32'd0);
    chk("abort_ovf", 32'(ov), 32'd0);
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    drive8(8'h01, 8'h01, 1'b1, 1'b0, '{8'h03, 1'b0, 1'b0});
    wait_done8(3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("post_rst_no_extra_done", 32'(done), 32'd0);

    // Single-chunk instance: one RUN cycle then DONE.
    for (int i = 0; i < 3; i++) begin
      s_a = v32[i].a; s_b = v32[i].b; s_cin = v32[i].cin; s_sub = v32[i].sub; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      chk("n1_busy", 32'(s_busy), 32'd1);
      s_a = 32'($urandom); s_b = 32'($urandom);
      @(negedge clk);
      chk("n1_done", 32'(s_done), 32'd1);
      chk("n1_sum", s_sum, v32[i].sum);
      chk("n1_carry", 32'(s_co), 32'(v32[i].co));
      chk("n1_ovf", 32'(s_ov), 32'(v32[i].ov));
      @(negedge clk);
      chk("n1_done_pulse", 32'(s_done), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
